// File: rtl/cpu_imem.sv
// cpu_imem: byte-loaded halfword instruction store with a combinational
// 48-bit (three-halfword) fetch port.
// States: IDLE -> LOAD (on load_start) -> RUN (on load_last or store full).
// Optional feature: define CPU_IMEM_BOUNDS_CHECK_EN to blank misaligned or
// out-of-range fetches and raise a sticky fault flag.

module cpu_imem #(
    parameter int DEPTH_HW = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] hatch_address,
    output logic [47:0] hatch_instruction,
    input  logic        load_start,
    input  logic [7:0]  load_data,
    input  logic        load_valid,
    input  logic        load_last,
    output logic        load_ready,
    output logic        load_done,
    output logic        running,
    output logic        fault
);

    localparam int AW = $clog2(DEPTH_HW);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   wr_ptr_d;
    logic            phase_q;
    logic [7:0]      hold_q;
    logic            load_done_q;
    logic            fault_q;

    logic [15:0]     mem_q [DEPTH_HW];

    logic            byte_accept;
    logic            store_full;
    logic            wr_en;
    logic [15:0]     wr_data;
    logic            load_complete;
    logic            fetch_bad;
    logic [AW-1:0]   rd_idx0;
    logic [AW-1:0]   rd_idx1;
    logic [AW-1:0]   rd_idx2;

    // Handshake and write-path decode. A load_start in the same cycle
    // discards the byte; rst blocks any write in its cycle.
    assign load_ready    = (state_q == ST_LOAD);
    assign running       = (state_q == ST_RUN);
    assign load_done     = load_done_q;
    assign fault         = fault_q;

    assign byte_accept   = load_valid & load_ready & ~load_start & ~rst;
    assign store_full    = (wr_ptr_q == AW'(DEPTH_HW - 1));
    // A halfword is written on every odd byte, or on an even byte that
    // ends the program (padded with a zero low byte).
    assign wr_en         = byte_accept & (phase_q | load_last);
    assign wr_data       = phase_q ? {hold_q, load_data} : {load_data, 8'h00};
    assign load_complete = byte_accept & (load_last | (phase_q & store_full));
    assign wr_ptr_d      = wr_ptr_q + AW'(1);

    // Fetch indices wrap naturally in AW-bit arithmetic.
    assign rd_idx0 = hatch_address[AW:1];
    assign rd_idx1 = rd_idx0 + AW'(1);
    assign rd_idx2 = rd_idx0 + AW'(2);

`ifdef CPU_IMEM_BOUNDS_CHECK_EN
    assign fetch_bad = hatch_address[0] | (hatch_address > 32'(2 * DEPTH_HW - 6));
`else
    // Without the check the low bit and the upper address bits are ignored.
    logic unused_addr;
    assign unused_addr = ^{hatch_address[31:AW+1], hatch_address[0]};
    assign fetch_bad   = 1'b0;
`endif

    // Combinational fetch: old contents are seen when a write to the same
    // halfword lands on the coming edge.
    always_comb begin
        // NOTE: default assignment first so every path drives the output and no latch is inferred.
        hatch_instruction = 48'h0;
        if (running && !fetch_bad) begin
            hatch_instruction = {mem_q[rd_idx0], mem_q[rd_idx1], mem_q[rd_idx2]};
        end
    end

    // Control FSM with registered load_done pulse and sticky fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            phase_q     <= 1'b0;
            hold_q      <= 8'h00;
            load_done_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            load_done_q <= 1'b0;
            if (load_start) begin
                state_q  <= ST_LOAD;
                wr_ptr_q <= '0;
                phase_q  <= 1'b0;
                fault_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_LOAD: begin
                        if (byte_accept) begin
                            phase_q <= ~phase_q;
                            if (!phase_q) begin
                                hold_q <= load_data;
                            end
                            if (wr_en) begin
                                wr_ptr_q <= wr_ptr_d;
                            end
                            if (load_complete) begin
                                state_q     <= ST_RUN;
                                load_done_q <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (fetch_bad) begin
                            fault_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Instruction store write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; programs persist across rst.
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_cpu_imem.sv
// tb_cpu_imem: self-checking bench for cpu_imem. A byte-array reference
// model tracks the program store and load progress; directed sequences and
// a vector table cover the corner cases, then a random phase runs long.
// Build with CPU_IMEM_BOUNDS_CHECK_EN to exercise the bounds-check variant.

module tb_cpu_imem;

    localparam int D  = 1024;
    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // DUT (DEPTH_HW = 1024) signals
    logic        rst, ls, lv, ll;
    logic [7:0]  ld;
    logic [31:0] addr;
    logic [47:0] instr;
    logic        lr, done, run, flt;

    // Small DUT (DEPTH_HW = 4) signals
    logic        s4, v4, l4;
    logic [7:0]  d4;
    logic [31:0] a4;
    logic [47:0] i4;
    logic        r4, dn4, rn4, f4;

    cpu_imem #(.DEPTH_HW(D)) dut (
        .clk(clk), .rst(rst), .hatch_address(addr), .hatch_instruction(instr),
        .load_start(ls), .load_data(ld), .load_valid(lv), .load_last(ll),
        .load_ready(lr), .load_done(done), .running(run), .fault(flt)
    );

    cpu_imem #(.DEPTH_HW(4)) dut4 (
        .clk(clk), .rst(rst), .hatch_address(a4), .hatch_instruction(i4),
        .load_start(s4), .load_data(d4), .load_valid(v4), .load_last(l4),
        .load_ready(r4), .load_done(dn4), .running(rn4), .fault(f4)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: program bytes in order, plus load progress.
    logic [7:0]  mb [2*D];
    int          mstate;
    int          mcount;
    logic [7:0]  mpend;
    logic        mdone;
    logic        mfault;

    logic [7:0]  q_bytes [$];

    typedef struct {
        int          grp;
        logic [31:0] addr;
        logic [47:0] exp;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] model_instr(input logic [31:0] a);
        logic [47:0] r;
        int          h0;
        int          h;
        r = '0;
        if (mstate != M_RUN) return r;
`ifdef CPU_IMEM_BOUNDS_CHECK_EN
        if (a[0] || a > 32'(2 * D - 6)) return r;
`endif
        h0 = int'((a >> 1) % 32'(D));
        for (int i = 0; i < 3; i++) begin
            h = (h0 + i) % D;
            r = {r[31:0], mb[2*h], mb[2*h+1]};
        end
        return r;
    endfunction

    task automatic model_step();
        if (rst) begin
            mstate = M_IDLE; mcount = 0; mpend = 8'h00; mdone = 1'b0; mfault = 1'b0;
        end else if (ls) begin
            mstate = M_LOAD; mcount = 0; mdone = 1'b0; mfault = 1'b0;
        end else begin
            mdone = 1'b0;
`ifdef CPU_IMEM_BOUNDS_CHECK_EN
            if (mstate == M_RUN && (addr[0] || addr > 32'(2 * D - 6))) mfault = 1'b1;
`endif
            if (mstate == M_LOAD && lv) begin
                if (mcount % 2 == 0) begin
                    if (ll) begin
                        mb[mcount] = ld; mb[mcount+1] = 8'h00;
                        mstate = M_RUN; mdone = 1'b1;
                    end else begin
                        mpend = ld;
                    end
                end else begin
                    mb[mcount-1] = mpend; mb[mcount] = ld;
                    if (ll || mcount == 2 * D - 1) begin
                        mstate = M_RUN; mdone = 1'b1;
                    end
                end
                mcount++;
            end
        end
    endtask

    // Called at a falling edge with inputs already applied: compare all
    // outputs to the model, advance the model, move to the next falling edge.
    task automatic tick();
        #1;
        check("load_ready", lr,    mstate == M_LOAD);
        check("running",    run,   mstate == M_RUN);
        check("load_done",  done,  mdone);
        check("fault",      flt,   mfault);
        check("instr",      instr, model_instr(addr));
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_q(input bit with_last);
        ls = 1'b1; tick(); ls = 1'b0;
        foreach (q_bytes[i]) begin
            lv = 1'b1; ld = q_bytes[i];
            ll = with_last && (i == q_bytes.size() - 1);
            tick();
        end
        lv = 1'b0; ll = 1'b0;
    endtask

    task automatic run_vectors(input int grp);
        foreach (vecs[i]) begin
            if (vecs[i].grp == grp) begin
                addr = vecs[i].addr;
                #1;
                check($sformatf("vec%0d_addr_%h", grp, vecs[i].addr), instr, vecs[i].exp);
                tick();
            end
        end
    endtask

    initial begin
        vecs[0] = '{1, 32'd0, 48'h010203040506};
        vecs[1] = '{1, 32'd6, 48'h0708090A0B0C};
        vecs[2] = '{1, 32'd2, 48'h030405060708};
        vecs[3] = '{1, 32'd4, 48'h05060708090A};
        vecs[4] = '{2, 32'd0, 48'hAAABACADAEAF};
        vecs[5] = '{2, 32'd4, 48'hAEAFB000090A};
        vecs[6] = '{3, 32'd0, 48'h616263646566};
        vecs[7] = '{3, 32'd6, 48'hB000090A0B0C};

        rst = 1'b1; ls = 1'b0; lv = 1'b0; ll = 1'b0; ld = 8'h00; addr = '0;
        s4 = 1'b0; v4 = 1'b0; l4 = 1'b0; d4 = 8'h00; a4 = '0;
        mstate = M_IDLE; mcount = 0; mpend = 8'h00; mdone = 1'b0; mfault = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        #1;
        check("reset_running", run, 1'b0);
        check("reset_ready",   lr,  1'b0);
        check("reset_instr",   instr, 48'h0);
        check("reset_fault",   flt, 1'b0);
        tick();

        // Fill the whole store without load_last: store-full ends the load.
        q_bytes.delete();
        for (int i = 0; i < 2 * D; i++) q_bytes.push_back(8'($urandom));
        load_q(1'b0);
        check("full_done", done, 1'b1);
        check("full_run",  run,  1'b1);
        lv = 1'b1; ld = 8'h5A;
        #1;
        check("full_not_ready", lr, 1'b0);
        tick();
        lv = 1'b0;

        // Top-of-store fetch wraps (or is blanked with the bounds check)
        addr = 32'h7FC;
        #1;
`ifdef CPU_IMEM_BOUNDS_CHECK_EN
        check("addr7fc_instr", instr, 48'h0);
`else
        check("addr7fc_instr", instr,
              {q_bytes[2044], q_bytes[2045], q_bytes[2046], q_bytes[2047], q_bytes[0], q_bytes[1]});
`endif
        tick();
        addr = 32'h0;
        #1;
`ifdef CPU_IMEM_BOUNDS_CHECK_EN
        check("addr7fc_fault", flt, 1'b1);
`else
        check("addr7fc_fault", flt, 1'b0);
`endif
        ls = 1'b1; tick(); ls = 1'b0;
        #1;
        check("fault_cleared", flt, 1'b0);

        // 12-byte program
        q_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                    8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
        load_q(1'b1);
        check("p12_done", done, 1'b1);
        check("p12_run",  run,  1'b1);
        run_vectors(1);

        // 7-byte program: odd tail padded, later halfwords persist
        q_bytes = '{8'hAA, 8'hAB, 8'hAC, 8'hAD, 8'hAE, 8'hAF, 8'hB0};
        load_q(1'b1);
        run_vectors(2);

        // Restart mid-load with load_valid held through the restart cycle
        ls = 1'b1; tick(); ls = 1'b0;
        for (int i = 0; i < 4; i++) begin lv = 1'b1; ld = 8'h51 + 8'(i); tick(); end
        ls = 1'b1; ld = 8'hEE;
        #1;
        check("restart_ready", lr, 1'b1);
        tick();
        ls = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ld = 8'h61 + 8'(i); ll = (i == 5); tick();
        end
        lv = 1'b0; ll = 1'b0;
        run_vectors(3);

        // Reset while running, then reload
        rst = 1'b1; tick(); rst = 1'b0;
        addr = 32'h0;
        #1;
        check("rst_run_running", run, 1'b0);
        check("rst_run_instr",   instr, 48'h0);
        q_bytes = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
        load_q(1'b1);
        #1;
        check("reload_instr", instr, 48'h212223242526);
        tick();

        // Small store: 10 bytes, no load_last, store fills after 8
        #1;
        check("d4_fault_idle", f4, 1'b0);
        s4 = 1'b1; tick(); s4 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            v4 = 1'b1; d4 = 8'h11 + 8'(i);
            #1;
            check($sformatf("d4_ready_%0d", i), r4,  i < 8);
            check($sformatf("d4_done_%0d", i),  dn4, i == 8);
            check($sformatf("d4_run_%0d", i),   rn4, i >= 8);
            tick();
        end
        v4 = 1'b0;
        a4 = 32'd0; #1; check("d4_addr0", i4, 48'h111213141516);
        a4 = 32'd2; #1; check("d4_addr2", i4, 48'h131415161718);
`ifdef CPU_IMEM_BOUNDS_CHECK_EN
        a4 = 32'd4; #1; check("d4_addr4", i4, 48'h0);
        a4 = 32'd1; #1; check("d4_addr1", i4, 48'h0);
`else
        a4 = 32'd4; #1; check("d4_addr4", i4, 48'h151617181112);
        a4 = 32'd1; #1; check("d4_addr1", i4, 48'h111213141516);
`endif
        tick();
        a4 = 32'd0;

        // Random phase against the reference model
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            ls  = ($urandom_range(0, 39) == 0);
            lv  = ($urandom_range(0, 9) < 7);
            ll  = ($urandom_range(0, 29) == 0);
            ld  = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       addr = {21'd0, 10'($urandom), 1'b0};
                1:       addr = 32'($urandom_range(0, 2 * D - 1));
                2:       addr = 32'(2 * D - 8 + int'($urandom_range(0, 7)));
                default: addr = $urandom;
            endcase
            tick();
        end
        rst = 1'b0; ls = 1'b0; lv = 1'b0; ll = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
